// File: rtl/mux2_sel_reg.sv
// mux2_sel_reg
// 2:1 operand selector with a registered copy of the selected word, a
// registered copy of the select line and a saturating count of clocked
// select changes.
//
// y is a plain ternary, so in simulation an X/Z select merges d0 and d1
// bitwise (equal bits pass, differing bits go X); synthesis sees a mux.

module mux2_sel_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] y_d;
  logic             sel_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sel_change;

  // Combinational selection; independent of clock, enable and reset.
  always_comb begin
    y = s ? d1 : d0;
  end

  // Next-state for the registered word and the select copy.
  always_comb begin
    y_d   = en ? y : y_q;
    sel_d = s;
  end

  // A change is counted only when the select seen at this edge differs
  // from the one captured at the previous edge; glitches that revert
  // between edges are invisible here by construction.
  always_comb begin
    sel_change = (s != sel_q);
    cnt_d      = cnt_q;
    if (sel_change && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      sel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_mux2_sel_reg.sv
// Scoreboard bench for mux2_sel_reg. A reference model pushes the expected
// registered state on each clock edge; an independent monitor pops and
// compares shortly after the edge. Combinational output is checked inline.

module tb_mux2_sel_reg;

  typedef struct packed {
    logic [15:0] yq;
    logic        sel;
    logic [7:0]  cnt8;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] d0, d1;
  logic        s, en;
  logic [15:0] y, y_q, y2, y_q2;
  logic        sel_q, sel_q2;
  logic [7:0]  toggle_cnt;
  logic [1:0]  toggle_cnt2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state
  logic [15:0] m_yq   = '0;
  logic        m_sel  = 1'b0;
  int          m_togs = 0;

  mux2_sel_reg #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .s(s), .en(en),
    .y(y), .y_q(y_q), .sel_q(sel_q), .toggle_cnt(toggle_cnt)
  );

  mux2_sel_reg #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .s(s), .en(en),
    .y(y2), .y_q(y_q2), .sel_q(sel_q2), .toggle_cnt(toggle_cnt2)
  );

  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: what the spec says the registers hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq   = '0;
      m_sel  = 1'b0;
      m_togs = 0;
      exp_q.delete();
    end else begin
      exp_t e;
      if (en) m_yq = (s == 1'b1) ? d1 : d0;
      if (s != m_sel) m_togs = m_togs + 1;
      m_sel  = s;
      e.yq   = m_yq;
      e.sel  = m_sel;
      e.cnt8 = 8'(sat(m_togs, 255));
      e.cnt2 = 2'(sat(m_togs, 3));
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT registered outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("y_q", 32'(y_q), 32'(e.yq));
        chk("sel_q", 32'(sel_q), 32'(e.sel));
        chk("toggle_cnt", 32'(toggle_cnt), 32'(e.cnt8));
        chk("toggle_cnt_w2", 32'(toggle_cnt2), 32'(e.cnt2));
        chk("y_q_w2", 32'(y_q2), 32'(e.yq));
      end
    end
  end

  task automatic chk_y(input string name);
    logic [15:0] want;
    want = s ? d1 : d0;
    #1;
    chk(name, 32'(y), 32'(want));
    chk({name, "_w2"}, 32'(y2), 32'(want));
  endtask

  task automatic drive_rand(input bit rand_en);
    @(negedge clk);
    d0 = 16'($urandom);
    d1 = 16'($urandom);
    s  = 1'($urandom);
    if (rand_en) en = 1'($urandom);
    chk_y("y_rand");
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = 16'hBEEF; d1 = 16'hDEAD; s = 1'b0; en = 1'b1;
    #1;
    chk("y_reset", 32'(y), 32'h0000BEEF);
    chk("y_q_reset", 32'(y_q), 32'h0);
    chk("sel_q_reset", 32'(sel_q), 32'h0);
    chk("cnt_reset", 32'(toggle_cnt), 32'h0);
    #4 rst_n = 1'b1;

    // T1/T2: first capture, then select switch mid-cycle
    @(posedge clk); #1;
    chk("t1_y_q", 32'(y_q), 32'h0000BEEF);
    #4;                    // t = 25
    s = 1'b1;
    chk_y("t2_y");
    chk("t2_y_const", 32'(y), 32'h0000DEAD);
    @(posedge clk); #1;
    chk("t2_sel_q", 32'(sel_q), 32'h1);
    chk("t2_cnt", 32'(toggle_cnt), 32'h1);
    chk("t2_y_q", 32'(y_q), 32'h0000DEAD);

    // T3: selected input change, then unselected change
    @(negedge clk);
    d1 = 16'hABCD;
    chk_y("t3_y");
    d0 = 16'h0000;
    #1;
    chk("t3_y_unsel", 32'(y), 32'h0000ABCD);
    @(posedge clk); #1;
    chk("t3_y_q", 32'(y_q), 32'h0000ABCD);

    // T4: en low, y tracks, y_q holds
    en = 1'b0;
    for (int i = 0; i < 8; i++) drive_rand(1'b0);
    @(posedge clk); #1;
    chk("t4_y_q_hold", 32'(y_q), 32'h0000ABCD);

    // T5: toggle every cycle; narrow counter saturates at 3
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s = ~s;
      chk_y("t5_y");
    end
    @(posedge clk); #1;
    chk("t5_cnt_w2_sat", 32'(toggle_cnt2), 32'h3);

    // random traffic
    for (int i = 0; i < 200; i++) drive_rand(1'b1);

    // drive the 8-bit counter into saturation
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s  = ~s;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
    end
    @(posedge clk); #1;
    chk("cnt8_sat", 32'(toggle_cnt), 32'd255);

    // T6: async reset between edges
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_y_q", 32'(y_q), 32'h0);
    chk("t6_sel_q", 32'(sel_q), 32'h0);
    chk("t6_cnt", 32'(toggle_cnt), 32'h0);
    chk("t6_cnt_w2", 32'(toggle_cnt2), 32'h0);
    s = 1'b1; d1 = 16'h1234; d0 = 16'h5678;
    chk_y("t6_y_in_reset");
    @(posedge clk); #1;
    chk("t6_hold_y_q", 32'(y_q), 32'h0);
    chk("t6_hold_cnt", 32'(toggle_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) drive_rand(1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
